// File: rtl/imem_boot_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory boot loader.
// Imported by the loader, the core integration and the bench.
package imem_boot_loader_pkg;

  localparam int INSTR_W    = 32;
  localparam int WORD_BYTES = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    ERR     = 3'd4
  } state_t;

endpackage

// File: rtl/imem_boot_loader.sv
// Boot sequencer: holds the core in reset, streams an image into imem,
// then releases core reset after a fixed hold time.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BOOT_PC     = 32'h0,
  parameter int          RST_HOLD    = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         load_valid,
  input  logic [INSTR_W-1:0]           load_data,
  input  logic                         load_last,
  output logic                         load_ready,
  output logic                         i_wr_e,
  output logic [31:0]                  i_wr_addr,
  output logic [INSTR_W-1:0]           i_wr_data,
  output logic                         core_rst_n,
  output logic [31:0]                  pc_rst,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic [$clog2(DEPTH_WORDS):0] word_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = AW + 1;
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int BW = $clog2(WORD_BYTES);

  state_t        state, state_nx;
  logic [HW-1:0] hold_cnt;
  logic          hs;
  logic          clr;

  assign load_ready = (state == LOAD);
  assign hs         = load_valid & load_ready;
  assign busy       = (state == LOAD) | (state == RELEASE);
  assign done       = (state == RUN);
  assign error      = (state == ERR);
  assign pc_rst     = BOOT_PC;

  always_comb begin
    state_nx = state;
    clr      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = LOAD;
          clr      = 1'b1;
        end
      end
      LOAD: begin
        // the DEPTH_WORDS-th word may carry last; one more would overflow
        if (hs) begin
          if (load_last)
            state_nx = RELEASE;
          else if (word_count == CW'(DEPTH_WORDS - 1))
            state_nx = ERR;
        end
      end
      RELEASE: begin
        if (hold_cnt == HW'(RST_HOLD - 1))
          state_nx = RUN;
      end
      RUN, ERR: begin
        if (start) begin
          state_nx = LOAD;
          clr      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      word_count <= '0;
      i_wr_e     <= 1'b0;
      i_wr_addr  <= '0;
      i_wr_data  <= '0;
      core_rst_n <= 1'b0;
    end else begin
      state      <= state_nx;
      i_wr_e     <= hs;
      core_rst_n <= (state_nx == RUN);
      if (state == RELEASE)
        hold_cnt <= hold_cnt + HW'(1);
      else
        hold_cnt <= '0;
      if (clr) begin
        word_count <= '0;
        i_wr_addr  <= '0;
      end else if (hs) begin
        word_count <= word_count + CW'(1);
        i_wr_addr  <= 32'(word_count[AW-1:0]) << BW;
        i_wr_data  <= load_data;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized directed bench for imem_boot_loader with a write-list
// reference model built from image contents and word indices.
module tb_imem_boot_loader;
  import imem_boot_loader_pkg::*;

  localparam int          DEPTH = 8;
  localparam int          HOLD  = 4;
  localparam logic [31:0] BPC   = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        i_wr_e;
  logic [31:0] i_wr_addr;
  logic [31:0] i_wr_data;
  logic        core_rst_n;
  logic [31:0] pc_rst;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  word_count;

  imem_boot_loader #(
    .DEPTH_WORDS(DEPTH),
    .BOOT_PC    (BPC),
    .RST_HOLD   (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .i_wr_e    (i_wr_e),
    .i_wr_addr (i_wr_addr),
    .i_wr_data (i_wr_data),
    .core_rst_n(core_rst_n),
    .pc_rst    (pc_rst),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [63:0] wr_q[$];
  int          last_wr_cyc = 0;
  always @(negedge clk)
    if (i_wr_e === 1'b1) begin
      wr_q.push_back({i_wr_addr, i_wr_data});
      last_wr_cyc = cyc;
    end

  logic [31:0] img[$];
  logic [63:0] exp_q[$];
  int total = 0;
  int passed = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic rand_img(input int n);
    img.delete();
    repeat (n) img.push_back($urandom);
  endtask

  task automatic do_start;
    start = 1'b1;
    step;
    start = 1'b0;
    wr_q.delete();
    exp_q.delete();
  endtask

  task automatic load_image(input int n, input bit last_final,
                            input int mode);
    for (int i = 0; i < n; i++) begin
      int gaps;
      bit hs;
      int b;
      gaps = (mode == 1 && i > 0) ? 1 :
             (mode == 2 ? int'($urandom_range(0, 2)) : 0);
      for (int g = 0; g < gaps; g++) begin
        load_valid = 1'b0;
        load_data  = $urandom;
        load_last  = 1'($urandom_range(0, 1));
        step;
        check("gap_no_write", i_wr_e, 0);
        check("gap_count", word_count, i);
      end
      load_valid = 1'b1;
      load_data  = img[i];
      load_last  = last_final && (i == n - 1);
      hs = 1'b0;
      b  = 0;
      while (!hs && b < 20) begin
        hs = load_ready;
        step;
        b++;
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("hs_seen", hs, 1);
      exp_q.push_back({32'(4 * i), img[i]});
      check("wr_pulse", i_wr_e, 1);
      check("wr_addr", i_wr_addr, 4 * i);
      check("wr_data", i_wr_data, img[i]);
      check("word_count", word_count, i + 1);
    end
  endtask

  task automatic wait_run(input int budget);
    int b;
    b = 0;
    while (core_rst_n !== 1'b1 && b < budget) begin
      step;
      b++;
    end
    check("run_reached", core_rst_n, 1);
    check("hold_time", cyc - last_wr_cyc, HOLD);
    check("run_done", done, 1);
    check("run_busy", busy, 0);
    check("run_error", error, 0);
  endtask

  task automatic compare_writes;
    int n;
    step;
    step;
    check("wr_total", wr_q.size(), exp_q.size());
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check("wr_entry", wr_q[i], exp_q[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"}, load_ready, 0);
    check({tag, "_wr_e"}, i_wr_e, 0);
    check({tag, "_addr"}, i_wr_addr, 0);
    check({tag, "_data"}, i_wr_data, 0);
    check({tag, "_core_rst_n"}, core_rst_n, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_count"}, word_count, 0);
    check({tag, "_pc_rst"}, pc_rst, BPC);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    load_valid = 1'b0;
    load_last  = 1'b0;
    load_data  = '0;
    repeat (3) step;
    check_reset_vals("rst");
    rst = 1'b1;
    step;
    check("idle_busy", busy, 0);

    img = {32'h0050_0093, 32'h0010_8113, 32'h0000_006F};
    do_start;
    check("t1_busy", busy, 1);
    check("t1_ready", load_ready, 1);
    load_image(3, 1'b1, 0);
    wait_run(20);
    compare_writes;

    rand_img(5);
    do_start;
    load_image(5, 1'b1, 1);
    wait_run(20);
    compare_writes;

    rand_img(8);
    do_start;
    load_image(8, 1'b0, 2);
    repeat (2) step;
    check("ovf_error", error, 1);
    check("ovf_core_rst_n", core_rst_n, 0);
    check("ovf_ready", load_ready, 0);
    check("ovf_done", done, 0);
    load_valid = 1'b1;
    repeat (3) step;
    load_valid = 1'b0;
    compare_writes;
    check("ovf_last_addr", wr_q[wr_q.size()-1][63:32], 32'h1C);

    rand_img(8);
    do_start;
    check("err_clear", error, 0);
    load_image(8, 1'b1, 2);
    wait_run(20);
    compare_writes;

    rand_img(2);
    do_start;
    check("reload_core_rst_n", core_rst_n, 0);
    check("reload_busy", busy, 1);
    check("reload_count", word_count, 0);
    load_image(2, 1'b1, 0);
    wait_run(20);
    compare_writes;

    rand_img(5);
    do_start;
    load_image(2, 1'b0, 2);
    #1 rst = 1'b0;
    #1 check_reset_vals("async");
    step;
    rst = 1'b1;
    wr_q.delete();
    load_valid = 1'b1;
    load_data  = $urandom;
    repeat (4) step;
    load_valid = 1'b0;
    check("post_rst_writes", wr_q.size(), 0);
    check("post_rst_count", word_count, 0);
    check("post_rst_ready", load_ready, 0);

    load_valid = 1'b1;
    load_data  = 32'hDEAD_BEEF;
    do_start;
    check("sv_no_write", i_wr_e, 0);
    check("sv_count", word_count, 0);
    check("sv_busy", busy, 1);
    rand_img(3);
    load_image(3, 1'b1, 0);
    wait_run(20);
    compare_writes;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
